// File: rtl/hazard_flow_ctrl.sv
// Backward pipeline control: load-use stall, EX redirect flush and halt drain/park sequencing.
// Optional saturating stall/flush performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_flow_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs2,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rd,
  input  logic             idex_halt,
  input  logic             ex_redirect,
  input  logic             resume,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic [DW-1:0] r_drainCnt;
  logic [DW-1:0] w_nextDrainCnt;
  logic          w_hz;

  assign w_hz = idex_mem_read && (idex_rd != 5'd0) &&
                ((idex_rd == id_rs1) || (id_uses_rs2 && (idex_rd == id_rs2)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= RUN;
      r_drainCnt <= '0;
    end else begin
      r_state    <= w_nextState;
      r_drainCnt <= w_nextDrainCnt;
    end
  end

  always_comb begin
    w_nextState    = r_state;
    w_nextDrainCnt = r_drainCnt;
    pc_write       = 1'b0;
    ifid_write     = 1'b0;
    ifid_flush     = 1'b1;
    idex_flush     = 1'b1;
    halted         = 1'b0;
    case (r_state)
      RUN: begin
        // Redirect beats halt and hazard: everything younger than the branch is wrong-path.
        if (ex_redirect) begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
        end else if (idex_halt) begin
          w_nextState    = DRAIN;
          w_nextDrainCnt = DW'(DRAIN_CYCLES - 1);
        end else if (w_hz) begin
          ifid_flush = 1'b0;
        end else begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
          ifid_flush = 1'b0;
          idex_flush = 1'b0;
        end
      end
      DRAIN: begin
        if (r_drainCnt == '0) begin
          w_nextState = HALTED;
        end else begin
          w_nextDrainCnt = r_drainCnt - 1'b1;
        end
      end
      HALTED: begin
        halted = 1'b1;
        if (resume) begin
          w_nextState = RUN;
        end
      end
      default: w_nextState = RUN;
    endcase
    // Hold the front end frozen and flushed for as long as reset is asserted.
    if (reset) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      halted     = 1'b0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic             w_stallEvt;
  logic             w_flushEvt;
  logic [CNT_W-1:0] r_stallCnt;
  logic [CNT_W-1:0] r_flushCnt;

  assign w_stallEvt = (r_state == RUN) && !ex_redirect && !idex_halt && w_hz;
  assign w_flushEvt = (r_state == RUN) && ex_redirect;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stallCnt <= '0;
      r_flushCnt <= '0;
    end else begin
      if (w_stallEvt && (r_stallCnt != {CNT_W{1'b1}})) begin
        r_stallCnt <= r_stallCnt + 1'b1;
      end
      if (w_flushEvt && (r_flushCnt != {CNT_W{1'b1}})) begin
        r_flushCnt <= r_flushCnt + 1'b1;
      end
    end
  end

  assign stall_cnt = r_stallCnt;
  assign flush_cnt = r_flushCnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
